// File: rtl/pkg_opengpu.sv
// Shared SIMT-core types: warp status encoding, per-warp context record, sizing constants.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
// Contents: WARPS_PER_CORE, DATA_WIDTH, WARP_SIZE, WARP_AGE_WIDTH, warp_status_t,
//           warp_context_t, warp_ctx_prio_sel (status next-state priority).
package pkg_opengpu;

  localparam int WARPS_PER_CORE = 4;
  localparam int DATA_WIDTH     = 32;
  localparam int WARP_SIZE      = 32;
  localparam int WARP_AGE_WIDTH = 8;

  // IDLE must stay the all-zero encoding: reset/abort clear contexts with '0.
  typedef enum logic [1:0] {
    WARP_IDLE    = 2'd0,
    WARP_READY   = 2'd1,
    WARP_BLOCKED = 2'd2,
    WARP_DONE    = 2'd3
  } warp_status_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc;
    logic [WARP_SIZE-1:0]      mask;
    warp_status_t              status;
    logic [WARP_AGE_WIDTH-1:0] age;
    logic                      valid;
  } warp_context_t;

  // Status next-state for a live warp, highest priority first:
  // explicit status write, mask emptied -> DONE, barrier wake of a BLOCKED warp, hold.
  function automatic warp_status_t warp_ctx_prio_sel(
    input warp_status_t cur,
    input logic         status_wr,
    input warp_status_t status_val,
    input logic         mask_zero_wr,
    input logic         wake
  );
    warp_status_t nxt;
    if (status_wr)                          nxt = status_val;
    else if (mask_zero_wr)                  nxt = WARP_DONE;
    else if (wake && cur == WARP_BLOCKED)   nxt = WARP_READY;
    else                                    nxt = cur;
    return nxt;
  endfunction

endpackage

// File: rtl/warp_age_arbiter.sv
// Oldest-request selector: binary max-age tree, ties resolved toward the lower id.
// Latency: purely combinational.
// Backpressure: none; result is a pure function of req/age.
// Ports: req[N] request vector, age[N*AGE_W] flattened ages (warp i at i*AGE_W),
//        vld any request present, id winning index.
module warp_age_arbiter #(
  parameter int N     = 4,
  parameter int ID_W  = $clog2(N),
  parameter int AGE_W = 8
) (
  input  logic [N-1:0]       req,
  input  logic [N*AGE_W-1:0] age,
  output logic               vld,
  output logic [ID_W-1:0]    id
);

  localparam int LVLS  = $clog2(N);
  localparam int P     = 1 << LVLS;
  localparam int NODES = 2 * P - 1;

  // Heap-ordered tree: node n has children 2n+1 (lower ids) and 2n+2.
  // Leaves sit at P-1..2P-2; padding leaves beyond N never request.
  logic             nd_vld [NODES];
  logic [AGE_W-1:0] nd_age [NODES];
  logic [ID_W-1:0]  nd_id  [NODES];

  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      nd_vld[n] = 1'b0;
      nd_age[n] = '0;
      nd_id[n]  = '0;
    end
    for (int i = 0; i < N; i++) begin
      nd_vld[P-1+i] = req[i];
      nd_age[P-1+i] = age[i*AGE_W +: AGE_W];
      nd_id[P-1+i]  = ID_W'(i);
    end
    // Children always have larger indices, so a descending sweep sees them resolved.
    // The right child wins only on strictly greater age, which keeps ties on the lower id.
    for (int n = P - 2; n >= 0; n--) begin
      if (nd_vld[2*n+2] && (!nd_vld[2*n+1] || nd_age[2*n+2] > nd_age[2*n+1])) begin
        nd_vld[n] = 1'b1;
        nd_age[n] = nd_age[2*n+2];
        nd_id[n]  = nd_id[2*n+2];
      end else begin
        nd_vld[n] = nd_vld[2*n+1];
        nd_age[n] = nd_age[2*n+1];
        nd_id[n]  = nd_id[2*n+1];
      end
    end
  end

  assign vld = nd_vld[0];
  assign id  = nd_id[0];

endmodule

// File: rtl/warp_context_table.sv
// Per-warp context table (pc, mask, status, age, valid) with ready/done summaries and oldest-ready pick.
// Latency: writes visible one clk later; summaries registered from next state; read/oldest paths combinational.
// Backpressure: none; every update is accepted in its cycle (abort > init > pc/mask/status/wake/issue).
// Ports: abort, init_*, pc_*, mask_*, status_*, barrier_wake, warp_issued/issued_warp_id in;
//        contexts, read_context (by read_warp_id), ready_mask, done_mask, all_done, oldest_ready_* out.
// Option: OPENGPU_WARP_PERF_EN adds perf_issue_cnt, a wrapping 32-bit issue counter per warp.
module warp_context_table
  import pkg_opengpu::*;
#(
  parameter int NUM_WARPS = WARPS_PER_CORE,
  parameter int WID_W     = $clog2(NUM_WARPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  abort,
  input  logic                  init_valid,
  input  logic [WID_W-1:0]      init_warp_id,
  input  logic [DATA_WIDTH-1:0] init_pc,
  input  logic [WARP_SIZE-1:0]  init_mask,
  input  logic                  pc_update,
  input  logic [WID_W-1:0]      pc_warp_id,
  input  logic [DATA_WIDTH-1:0] new_pc,
  input  logic                  mask_update,
  input  logic [WID_W-1:0]      mask_warp_id,
  input  logic [WARP_SIZE-1:0]  new_mask,
  input  logic                  status_update,
  input  logic [WID_W-1:0]      status_warp_id,
  input  warp_status_t          new_status,
  input  logic [NUM_WARPS-1:0]  barrier_wake,
  input  logic                  warp_issued,
  input  logic [WID_W-1:0]      issued_warp_id,
  output warp_context_t         contexts [NUM_WARPS],
  input  logic [WID_W-1:0]      read_warp_id,
  output warp_context_t         read_context,
  output logic [NUM_WARPS-1:0]  ready_mask,
  output logic [NUM_WARPS-1:0]  done_mask,
  output logic                  all_done,
  output logic                  oldest_ready_valid,
  output logic [WID_W-1:0]      oldest_ready_id
`ifdef OPENGPU_WARP_PERF_EN
  ,
  output logic [31:0]           perf_issue_cnt [NUM_WARPS]
`endif
);

  localparam int AGE_WIDTH = WARP_AGE_WIDTH;
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  warp_context_t ctx_q [NUM_WARPS];
  warp_context_t ctx_d [NUM_WARPS];

  // Id decode; an out-of-range id matches no slot and is therefore ignored.
  logic [NUM_WARPS-1:0] init_hit, pc_hit, mask_hit, stat_hit, iss_hit;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      init_hit[w] = init_valid    && (init_warp_id   == WID_W'(w));
      pc_hit[w]   = pc_update     && (pc_warp_id     == WID_W'(w));
      mask_hit[w] = mask_update   && (mask_warp_id   == WID_W'(w));
      stat_hit[w] = status_update && (status_warp_id == WID_W'(w));
      iss_hit[w]  = warp_issued   && (issued_warp_id == WID_W'(w));
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      ctx_d[w] = ctx_q[w];
      if (abort) begin
        ctx_d[w] = '0;
      end else if (init_hit[w]) begin
        ctx_d[w].pc     = init_pc;
        ctx_d[w].mask   = init_mask;
        ctx_d[w].status = WARP_READY;
        ctx_d[w].age    = '0;
        ctx_d[w].valid  = 1'b1;
      end else if (ctx_q[w].valid) begin
        if (pc_hit[w])   ctx_d[w].pc   = new_pc;
        if (mask_hit[w]) ctx_d[w].mask = new_mask;
        ctx_d[w].status = warp_ctx_prio_sel(ctx_q[w].status, stat_hit[w], new_status,
                                            mask_hit[w] && (new_mask == '0), barrier_wake[w]);
        // Ageing advances only on issue cycles and looks at the pre-update status.
        if (warp_issued) begin
          if (iss_hit[w])
            ctx_d[w].age = '0;
          else if (ctx_q[w].status == WARP_READY && ctx_q[w].age != AGE_MAX)
            ctx_d[w].age = ctx_q[w].age + 1'b1;
        end
      end
    end
  end

  logic [NUM_WARPS-1:0] ready_d, done_d;
  logic                 any_valid_d, all_valid_done_d, all_done_d;

  always_comb begin
    any_valid_d      = 1'b0;
    all_valid_done_d = 1'b1;
    for (int w = 0; w < NUM_WARPS; w++) begin
      ready_d[w] = ctx_d[w].valid && (ctx_d[w].status == WARP_READY);
      done_d[w]  = ctx_d[w].valid && (ctx_d[w].status == WARP_DONE);
      any_valid_d      = any_valid_d | ctx_d[w].valid;
      all_valid_done_d = all_valid_done_d & (!ctx_d[w].valid || ctx_d[w].status == WARP_DONE);
    end
    // Kernel completion is sticky: once reached, only a new launch or an abort drops it.
    if (abort || (|init_hit))
      all_done_d = 1'b0;
    else
      all_done_d = all_done | (any_valid_d & all_valid_done_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) ctx_q[w] <= '0;
      ready_mask <= '0;
      done_mask  <= '0;
      all_done   <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) ctx_q[w] <= ctx_d[w];
      ready_mask <= ready_d;
      done_mask  <= done_d;
      all_done   <= all_done_d;
    end
  end

  assign contexts = ctx_q;

  always_comb begin
    read_context = '0;
    for (int w = 0; w < NUM_WARPS; w++)
      if (read_warp_id == WID_W'(w)) read_context = ctx_q[w];
  end

  // ready_mask already equals valid && READY of the current state, so it is the request vector.
  logic [NUM_WARPS*AGE_WIDTH-1:0] arb_age;

  always_comb begin
    arb_age = '0;
    for (int w = 0; w < NUM_WARPS; w++) arb_age[w*AGE_WIDTH +: AGE_WIDTH] = ctx_q[w].age;
  end

  warp_age_arbiter #(
    .N     (NUM_WARPS),
    .ID_W  (WID_W),
    .AGE_W (AGE_WIDTH)
  ) u_age_arb (
    .req (ready_mask),
    .age (arb_age),
    .vld (oldest_ready_valid),
    .id  (oldest_ready_id)
  );

`ifdef OPENGPU_WARP_PERF_EN
  logic [31:0] perf_q [NUM_WARPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) perf_q[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (abort || init_hit[w])
          perf_q[w] <= '0;
        else if (iss_hit[w] && ctx_q[w].valid)
          perf_q[w] <= perf_q[w] + 32'd1;
      end
    end
  end

  assign perf_issue_cnt = perf_q;
`endif

endmodule

// File: tb/tb_warp_context_table.sv
module tb_warp_context_table;
  import pkg_opengpu::*;

  localparam int NW = 4;
  localparam int WW = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  abort;
  logic                  init_valid;
  logic [WW-1:0]         init_warp_id;
  logic [DATA_WIDTH-1:0] init_pc;
  logic [WARP_SIZE-1:0]  init_mask;
  logic                  pc_update;
  logic [WW-1:0]         pc_warp_id;
  logic [DATA_WIDTH-1:0] new_pc;
  logic                  mask_update;
  logic [WW-1:0]         mask_warp_id;
  logic [WARP_SIZE-1:0]  new_mask;
  logic                  status_update;
  logic [WW-1:0]         status_warp_id;
  warp_status_t          new_status;
  logic [NW-1:0]         barrier_wake;
  logic                  warp_issued;
  logic [WW-1:0]         issued_warp_id;
  warp_context_t         contexts [NW];
  logic [WW-1:0]         read_warp_id;
  warp_context_t         read_context;
  logic [NW-1:0]         ready_mask;
  logic [NW-1:0]         done_mask;
  logic                  all_done;
  logic                  oldest_ready_valid;
  logic [WW-1:0]         oldest_ready_id;
`ifdef OPENGPU_WARP_PERF_EN
  logic [31:0]           perf_issue_cnt [NW];
`endif

  warp_context_table #(.NUM_WARPS(NW), .WID_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .init_valid(init_valid), .init_warp_id(init_warp_id), .init_pc(init_pc), .init_mask(init_mask),
    .pc_update(pc_update), .pc_warp_id(pc_warp_id), .new_pc(new_pc),
    .mask_update(mask_update), .mask_warp_id(mask_warp_id), .new_mask(new_mask),
    .status_update(status_update), .status_warp_id(status_warp_id), .new_status(new_status),
    .barrier_wake(barrier_wake), .warp_issued(warp_issued), .issued_warp_id(issued_warp_id),
    .contexts(contexts), .read_warp_id(read_warp_id), .read_context(read_context),
    .ready_mask(ready_mask), .done_mask(done_mask), .all_done(all_done),
    .oldest_ready_valid(oldest_ready_valid), .oldest_ready_id(oldest_ready_id)
`ifdef OPENGPU_WARP_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: one record per warp plus the sticky completion flag.
  warp_context_t m [NW];
  logic          m_all_done;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NW; w++) m[w] = '0;
    m_all_done = 1'b0;
  endtask

  // Applies one clock of the table's rules to the reference state.
  task automatic model_step();
    warp_context_t n [NW];
    logic launched, any_live, all_finished;
    if (abort) begin
      model_reset();
      return;
    end
    n = m;
    launched = 1'b0;
    for (int w = 0; w < NW; w++) begin
      if (init_valid && int'(init_warp_id) == w) begin
        n[w].pc = init_pc; n[w].mask = init_mask; n[w].status = WARP_READY;
        n[w].age = 0; n[w].valid = 1'b1;
        launched = 1'b1;
      end else if (m[w].valid) begin
        if (pc_update && int'(pc_warp_id) == w) n[w].pc = new_pc;
        if (mask_update && int'(mask_warp_id) == w) n[w].mask = new_mask;
        if (status_update && int'(status_warp_id) == w) n[w].status = new_status;
        else if (mask_update && int'(mask_warp_id) == w && new_mask == 0) n[w].status = WARP_DONE;
        else if (barrier_wake[w] && m[w].status == WARP_BLOCKED) n[w].status = WARP_READY;
        if (warp_issued) begin
          if (int'(issued_warp_id) == w) n[w].age = 0;
          else if (m[w].status == WARP_READY) n[w].age = (int'(m[w].age) >= 255) ? 8'd255 : m[w].age + 8'd1;
        end
      end
    end
    m = n;
    any_live = 1'b0;
    all_finished = 1'b1;
    for (int w = 0; w < NW; w++) begin
      if (m[w].valid) any_live = 1'b1;
      if (m[w].valid && m[w].status != WARP_DONE) all_finished = 1'b0;
    end
    m_all_done = launched ? 1'b0 : (m_all_done || (any_live && all_finished));
  endtask

  task automatic check_all(input string ph);
    logic [NW-1:0] er, ed;
    int best;
    er = '0; ed = '0; best = -1;
    for (int w = 0; w < NW; w++) begin
      er[w] = m[w].valid && m[w].status == WARP_READY;
      ed[w] = m[w].valid && m[w].status == WARP_DONE;
      if (er[w] && (best < 0 || m[w].age > m[best].age)) best = w;
      chk($sformatf("%s ctx%0d", ph, w), 128'(contexts[w]), 128'(m[w]));
    end
    chk({ph, " ready_mask"}, 128'(ready_mask), 128'(er));
    chk({ph, " done_mask"}, 128'(done_mask), 128'(ed));
    chk({ph, " all_done"}, 128'(all_done), 128'(m_all_done));
    chk({ph, " read_ctx"}, 128'(read_context), 128'(m[read_warp_id]));
    chk({ph, " oldest_vld"}, 128'(oldest_ready_valid), 128'(best >= 0));
    if (best >= 0) chk({ph, " oldest_id"}, 128'(oldest_ready_id), 128'(best));
  endtask

  task automatic clear_inputs();
    abort = 0; init_valid = 0; init_warp_id = 0; init_pc = 0; init_mask = 0;
    pc_update = 0; pc_warp_id = 0; new_pc = 0;
    mask_update = 0; mask_warp_id = 0; new_mask = 0;
    status_update = 0; status_warp_id = 0; new_status = WARP_IDLE;
    barrier_wake = 0; warp_issued = 0; issued_warp_id = 0;
  endtask

  task automatic step(input string ph);
    model_step();
    @(posedge clk);
    #1;
    check_all(ph);
    clear_inputs();
  endtask

  task automatic do_init(input int w, input logic [31:0] pc, input logic [31:0] mk);
    init_valid = 1; init_warp_id = WW'(w); init_pc = pc; init_mask = mk;
    step("init");
  endtask

  task automatic do_issue(input int w);
    warp_issued = 1; issued_warp_id = WW'(w);
    step("issue");
  endtask

  initial begin
    rst_n = 0;
    read_warp_id = 2;
    clear_inputs();
    model_reset();
    #12;
    check_all("reset");
    chk("reset ready_mask", 128'(ready_mask), 128'(0));
    @(negedge clk);
    rst_n = 1;

    // Launch warp 2.
    do_init(2, 32'h100, 32'hFFFF_FFFF);
    chk("tp1 ready_mask", 128'(ready_mask), 128'(4'b0100));
    chk("tp1 oldest_id", 128'(oldest_ready_id), 128'(2));
    chk("tp1 status2", 128'(contexts[2].status), 128'(WARP_READY));

    // Ageing and saturation.
    read_warp_id = 1;
    do_init(0, 32'h200, 32'h0000_00FF);
    do_init(1, 32'h300, 32'hFFFF_0000);
    for (int i = 0; i < 3; i++) do_issue(0);
    chk("tp2 age1", 128'(contexts[1].age), 128'(3));
    chk("tp2 age0", 128'(contexts[0].age), 128'(0));
    for (int i = 0; i < 255; i++) do_issue(0);
    chk("tp2 age1 sat", 128'(contexts[1].age), 128'(255));
    do_issue(1);
    chk("tp2 age1 clr", 128'(contexts[1].age), 128'(0));

    // Status priority, wake of blocked and ready warps.
    status_update = 1; status_warp_id = 1; new_status = WARP_BLOCKED;
    mask_update = 1; mask_warp_id = 1; new_mask = 0;
    step("tp3 blk");
    chk("tp3 blocked", 128'(contexts[1].status), 128'(WARP_BLOCKED));
    barrier_wake = 4'b0010;
    step("tp3 wake");
    chk("tp3 woken", 128'(contexts[1].status), 128'(WARP_READY));
    barrier_wake = 4'b0011;
    step("tp3 rewake");
    chk("tp3 nochg", 128'(contexts[1].status), 128'(WARP_READY));

    // Kernel completion.
    do_init(3, 32'h400, 32'h1);
    for (int w = 0; w < NW; w++) begin
      chk("tp4 not done yet", 128'(all_done), 128'(0));
      mask_update = 1; mask_warp_id = WW'(w); new_mask = 0;
      step("tp4 mask0");
    end
    chk("tp4 done_mask", 128'(done_mask), 128'(4'hF));
    chk("tp4 all_done", 128'(all_done), 128'(1));
    step("tp4 idle");
    chk("tp4 all_done sticky", 128'(all_done), 128'(1));
    do_init(0, 32'h500, 32'hF);
    chk("tp4 all_done clr", 128'(all_done), 128'(0));

    // Oldest-ready tie break.
    abort = 1;
    step("tp5 abort");
    do_init(0, 32'h10, 32'h3);
    do_init(3, 32'h30, 32'h3);
    do_init(1, 32'h20, 32'h3);
    for (int i = 0; i < 5; i++) do_issue(1);
    chk("tp5 age0", 128'(contexts[0].age), 128'(5));
    chk("tp5 age3", 128'(contexts[3].age), 128'(5));
    chk("tp5 tie id", 128'(oldest_ready_id), 128'(0));
    status_update = 1; status_warp_id = 0; new_status = WARP_BLOCKED;
    step("tp5 blk0");
    chk("tp5 next id", 128'(oldest_ready_id), 128'(3));

    // Abort beats a same-cycle init.
    abort = 1; init_valid = 1; init_warp_id = 2; init_pc = 32'hDEAD; init_mask = 32'hFF;
    warp_issued = 1; issued_warp_id = 3;
    step("tp6 abort");
    chk("tp6 ready_mask", 128'(ready_mask), 128'(0));
    chk("tp6 valid2", 128'(contexts[2].valid), 128'(0));

    // Asynchronous reset mid-cycle.
    do_init(1, 32'h77, 32'h7);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_all("tp6 async rst");
    chk("tp6 async ready", 128'(ready_mask), 128'(0));
    @(negedge clk);
    rst_n = 1;

    // Randomised traffic.
    for (int c = 0; c < 600; c++) begin
      abort          = ($urandom_range(0, 59) == 0);
      init_valid     = ($urandom_range(0, 3) == 0);
      init_warp_id   = WW'($urandom_range(0, NW - 1));
      init_pc        = $urandom;
      init_mask      = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      pc_update      = $urandom_range(0, 1);
      pc_warp_id     = WW'($urandom_range(0, NW - 1));
      new_pc         = $urandom;
      mask_update    = ($urandom_range(0, 3) == 0);
      mask_warp_id   = WW'($urandom_range(0, NW - 1));
      new_mask       = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      status_update  = ($urandom_range(0, 5) == 0);
      status_warp_id = WW'($urandom_range(0, NW - 1));
      new_status     = warp_status_t'($urandom_range(0, 3));
      barrier_wake   = NW'($urandom_range(0, 15));
      warp_issued    = $urandom_range(0, 1);
      issued_warp_id = WW'($urandom_range(0, NW - 1));
      read_warp_id   = WW'($urandom_range(0, NW - 1));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
